// File: rtl/auction_bid_collector_pkg.sv
// Shared constants, FSM state type and helpers for the 10-way auction bid collector.
package auction_pkg;

  localparam int unsigned NBID  = 10;
  localparam int unsigned IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    EVAL,
    GRANT
  } state_e;

  // Indices outside 0..NBID-1 match no bit and yield an all-zero vector.
  function automatic logic [NBID-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    logic [NBID-1:0] oh;
    oh = '0;
    for (int unsigned i = 0; i < NBID; i++) begin
      if (idx == IDX_W'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/auction_bid_collector_if.sv
// Bidder-side and grant-side handshakes of the auction bid collector.
interface auction_bid_collector_if #(
  parameter int unsigned bW = 17
);
  import auction_pkg::*;

  logic [NBID-1:0]         bid_valid;
  logic [NBID-1:0][bW-1:0] bid_value;
  logic [NBID-1:0]         bid_ready;
  logic                    grant_valid;
  logic                    grant_ready;
  logic [NBID-1:0]         grant_onehot;
  logic [bW-1:0]           grant_bid;
  logic                    grant_err;

  modport master (
    output bid_valid, bid_value, grant_ready,
    input  bid_ready, grant_valid, grant_onehot, grant_bid, grant_err
  );

  modport slave (
    input  bid_valid, bid_value, grant_ready,
    output bid_ready, grant_valid, grant_onehot, grant_bid, grant_err
  );

endinterface

// File: rtl/auction_bid_collector_tmo_cnt.sv
// Collection-timeout counter: runs from the first accepted bid until cleared.
module auction_tmo_cnt #(
  parameter int unsigned TMO_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             start_i,
  input  logic [TMO_W-1:0] round_timeout_i,
  output logic             expired_o
);

  logic             run_q;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             tick;

  // The accept cycle itself counts as the first tick, so expiry lands
  // round_timeout cycles after the first accept.
  assign tick      = run_q | start_i;
  assign cnt_d     = tick ? cnt_q + TMO_W'(1) : cnt_q;
  assign expired_o = tick && (round_timeout_i != '0) && (cnt_d == round_timeout_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q <= 1'b0;
      cnt_q <= '0;
    end else if (clear_i) begin
      run_q <= 1'b0;
      cnt_q <= '0;
    end else if (tick) begin
      run_q <= 1'b1;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/auction_bid_collector.sv
// Collects one bid per bidder, hands the frozen vector to the argmax stage,
// and issues a one-hot grant for the returned winner index.
module auction_bid_collector
  import auction_pkg::*;
#(
  parameter int unsigned bW    = 17,
  parameter int unsigned TMO_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  auction_bid_collector_if.slave  bus,
  input  logic [TMO_W-1:0]        round_timeout,
  output logic [NBID-1:0][bW-1:0] bids_out,
  input  logic [IDX_W-1:0]        win_in,
  output logic [7:0]              round_id
);

  state_e                  state_q, state_d;
  logic [NBID-1:0]         mask_q, mask_d;
  logic [NBID-1:0]         ready_q, ready_d;
  logic [NBID-1:0]         accept;
  logic [NBID-1:0][bW-1:0] bids_q;
  logic                    eval_second_q;
  logic                    gvalid_q;
  logic [NBID-1:0]         gonehot_q;
  logic [bW-1:0]           gbid_q;
  logic                    gerr_q;
  logic [7:0]              round_q;
  logic                    tmo_expired;

  // ready_q is only non-zero in COLLECT, so it also gates acceptance.
  assign accept = bus.bid_valid & ready_q;

  auction_tmo_cnt #(.TMO_W(TMO_W)) u_tmo (
    .clk             (clk),
    .rst             (rst),
    .clear_i         (state_q != COLLECT),
    .start_i         (|accept),
    .round_timeout_i (round_timeout),
    .expired_o       (tmo_expired)
  );

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    unique case (state_q)
      IDLE: begin
        state_d = COLLECT;
        mask_d  = '0;
      end
      COLLECT: begin
        mask_d = mask_q | accept;
        if ((&mask_d) || tmo_expired) state_d = EVAL;
      end
      EVAL:    if (eval_second_q) state_d = GRANT;
      GRANT:   if (bus.grant_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == COLLECT) ? ~mask_d : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      mask_q        <= '0;
      ready_q       <= '0;
      bids_q        <= '0;
      eval_second_q <= 1'b0;
      gvalid_q      <= 1'b0;
      gonehot_q     <= '0;
      gbid_q        <= '0;
      gerr_q        <= 1'b0;
      round_q       <= '0;
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      ready_q       <= ready_d;
      eval_second_q <= (state_q == EVAL) && !eval_second_q;
      if (state_q == IDLE) begin
        bids_q <= '0;
      end else begin
        for (int unsigned i = 0; i < NBID; i++) begin
          if (accept[i]) bids_q[i] <= bus.bid_value[i];
        end
      end
      if (state_q == EVAL && eval_second_q) begin
        gvalid_q  <= 1'b1;
        gonehot_q <= idx_onehot(win_in);
        if (win_in < IDX_W'(NBID)) begin
          gbid_q <= bids_q[win_in];
          gerr_q <= 1'b0;
        end else begin
          gbid_q <= '0;
          gerr_q <= 1'b1;
        end
      end else if (state_q == GRANT && bus.grant_ready) begin
        gvalid_q  <= 1'b0;
        gonehot_q <= '0;
        gbid_q    <= '0;
        gerr_q    <= 1'b0;
        round_q   <= round_q + 8'd1;
      end
    end
  end

  assign bus.bid_ready    = ready_q;
  assign bus.grant_valid  = gvalid_q;
  assign bus.grant_onehot = gonehot_q;
  assign bus.grant_bid    = gbid_q;
  assign bus.grant_err    = gerr_q;
  assign bids_out         = bids_q;
  assign round_id         = round_q;

endmodule
